// File: rtl/demux8_pipe_if.sv
// Bundle of the routed input word, the eight lane outputs with their
// handshakes, and the accepted-word counter.
interface demux8_pipe_if #(
  parameter int N = 64
);
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   s;
  logic [N-1:0] d;
  logic [N-1:0] y0;
  logic [N-1:0] y1;
  logic [N-1:0] y2;
  logic [N-1:0] y3;
  logic [N-1:0] y4;
  logic [N-1:0] y5;
  logic [N-1:0] y6;
  logic [N-1:0] y7;
  logic [7:0]   out_valid;
  logic [7:0]   out_ready;
  logic [15:0]  xfer_cnt;

  // Producer/consumer side: drives the input word and the lane ready flags.
  modport master (
    output in_valid, s, d, out_ready,
    input  in_ready, y0, y1, y2, y3, y4, y5, y6, y7, out_valid, xfer_cnt
  );

  // Demux side.
  modport slave (
    input  in_valid, s, d, out_ready,
    output in_ready, y0, y1, y2, y3, y4, y5, y6, y7, out_valid, xfer_cnt
  );
endinterface

// File: rtl/demux8_pipe.sv
// Eight-lane registered demultiplexer. Each lane holds one word behind a
// valid/ready handshake; a lane may be drained and reloaded on the same edge.
//
// Per-lane states:
//   state | meaning
//   EMPTY | lane holds no unconsumed word, out_valid[k] = 0
//   FULL  | lane holds a word waiting for out_ready[k], out_valid[k] = 1
module demux8_pipe #(
  parameter int N = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  demux8_pipe_if.slave    bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } lane_state_e;

  lane_state_e  st_q  [8];
  logic [N-1:0] y_q   [8];
  logic [15:0]  cnt_q;
  logic [7:0]   vld;
  logic         in_ready;
  logic         accept;

  // Lane valid flags are the registered lane states.
  always_comb begin
    vld = 8'h00;
    for (int k = 0; k < 8; k++) begin
      vld[k] = (st_q[k] == FULL);
    end
  end

  // The addressed lane can take a word if it is empty or is being drained now.
  always_comb begin
    in_ready = ~vld[bus.s] | bus.out_ready[bus.s];
    accept   = bus.in_valid & in_ready;
  end

  // Lane state machines, holding registers and the accepted-word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) begin
        st_q[k] <= EMPTY;
        y_q[k]  <= '0;
      end
      cnt_q <= 16'h0000;
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (accept && (bus.s == 3'(k))) begin
          st_q[k] <= FULL;
          y_q[k]  <= bus.d;
        end else if (st_q[k] == FULL && bus.out_ready[k]) begin
          st_q[k] <= EMPTY;
        end
      end
      if (accept) begin
        cnt_q <= cnt_q + 16'h0001;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = vld;
  assign bus.xfer_cnt  = cnt_q;
  assign bus.y0        = y_q[0];
  assign bus.y1        = y_q[1];
  assign bus.y2        = y_q[2];
  assign bus.y3        = y_q[3];
  assign bus.y4        = y_q[4];
  assign bus.y5        = y_q[5];
  assign bus.y6        = y_q[6];
  assign bus.y7        = y_q[7];

endmodule

// File: tb/tb_demux8_pipe.sv
// Directed bench for demux8_pipe with a per-lane scoreboard that is updated
// from the bench's own model of lane occupancy and compared every cycle.
module tb_demux8_pipe;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  demux8_pipe_if #(.N(64)) bus ();

  demux8_pipe #(.N(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] sb_q [8][$];
  logic [15:0] exp_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] y_of(input int k);
    case (k)
      0: return bus.y0;
      1: return bus.y1;
      2: return bus.y2;
      3: return bus.y3;
      4: return bus.y4;
      5: return bus.y5;
      6: return bus.y6;
      default: return bus.y7;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: at each falling edge predict the coming rising edge.
  always @(negedge clk) begin
    logic [7:0] exp_vld;
    logic       exp_rdy;
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) sb_q[k].delete();
      exp_cnt = 16'h0000;
      chk("rst_out_valid", {56'h0, bus.out_valid}, 64'h0);
      chk("rst_xfer_cnt", {48'h0, bus.xfer_cnt}, 64'h0);
      chk("rst_in_ready", {63'h0, bus.in_ready}, 64'h1);
    end else begin
      exp_vld = 8'h00;
      for (int k = 0; k < 8; k++) exp_vld[k] = (sb_q[k].size() != 0);
      chk("sb_out_valid", {56'h0, bus.out_valid}, {56'h0, exp_vld});
      chk("sb_xfer_cnt", {48'h0, bus.xfer_cnt}, {48'h0, exp_cnt});
      for (int k = 0; k < 8; k++) begin
        if (exp_vld[k]) chk($sformatf("sb_y%0d", k), y_of(k), sb_q[k][0]);
      end
      exp_rdy = ~exp_vld[bus.s] | bus.out_ready[bus.s];
      chk("sb_in_ready", {63'h0, bus.in_ready}, {63'h0, exp_rdy});
      for (int k = 0; k < 8; k++) begin
        if (exp_vld[k] && bus.out_ready[k]) void'(sb_q[k].pop_front());
      end
      if (bus.in_valid && exp_rdy) begin
        sb_q[bus.s].push_back(bus.d);
        exp_cnt = exp_cnt + 16'h0001;
      end
    end
  end

  initial begin
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.s         = 3'd0;
    bus.d         = 64'h0;
    bus.out_ready = 8'h00;

    // Reset state
    #3;
    chk("reset_out_valid", {56'h0, bus.out_valid}, 64'h0);
    chk("reset_xfer_cnt", {48'h0, bus.xfer_cnt}, 64'h0);
    chk("reset_in_ready", {63'h0, bus.in_ready}, 64'h1);
    chk("reset_y0", bus.y0, 64'h0);
    chk("reset_y5", bus.y5, 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Routing to all eight lanes
    bus.in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.s = 3'(k);
      bus.d = 64'(10 + k);
      step();
    end
    bus.in_valid = 1'b0;
    chk("route_out_valid", {56'h0, bus.out_valid}, 64'hFF);
    for (int k = 0; k < 8; k++) chk($sformatf("route_y%0d", k), y_of(k), 64'(10 + k));
    chk("route_xfer_cnt", {48'h0, bus.xfer_cnt}, 64'd8);

    // Back-pressure on lane 3
    bus.out_ready = 8'hFF;
    step();
    bus.out_ready = 8'h00;
    chk("drain_all", {56'h0, bus.out_valid}, 64'h0);
    bus.in_valid = 1'b1;
    bus.s        = 3'd3;
    bus.d        = 64'd5;
    step();
    bus.d = 64'd9;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_in_ready", {63'h0, bus.in_ready}, 64'h0);
      chk("bp_y3_hold", bus.y3, 64'd5);
      chk("bp_xfer_cnt", {48'h0, bus.xfer_cnt}, 64'd9);
      step();
    end
    bus.out_ready = 8'h08;
    #1;
    chk("bp_release_ready", {63'h0, bus.in_ready}, 64'h1);
    step();
    chk("bp_y3_new", bus.y3, 64'd9);
    chk("bp_valid3_kept", {63'h0, bus.out_valid[3]}, 64'h1);
    chk("bp_xfer_cnt_after", {48'h0, bus.xfer_cnt}, 64'd10);
    bus.in_valid = 1'b0;
    step();
    bus.out_ready = 8'h00;
    chk("bp_drained", {56'h0, bus.out_valid}, 64'h0);

    // Pass-through stream on lane 2
    bus.out_ready = 8'hFF;
    bus.s         = 3'd2;
    bus.in_valid  = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      bus.d = 64'(i);
      #1;
      chk("pt_in_ready", {63'h0, bus.in_ready}, 64'h1);
      step();
      chk("pt_y2", bus.y2, 64'(i));
      chk("pt_valid2", {63'h0, bus.out_valid[2]}, 64'h1);
    end
    bus.in_valid = 1'b0;
    step();
    bus.out_ready = 8'h00;

    // Lane independence: lane 7 stalled, lane 0 still accepts
    bus.in_valid = 1'b1;
    bus.s        = 3'd7;
    bus.d        = 64'd77;
    step();
    bus.s = 3'd0;
    bus.d = 64'd42;
    #1;
    chk("ind_in_ready", {63'h0, bus.in_ready}, 64'h1);
    step();
    bus.in_valid = 1'b0;
    chk("ind_y0", bus.y0, 64'd42);
    chk("ind_y7", bus.y7, 64'd77);
    chk("ind_out_valid", {56'h0, bus.out_valid}, 64'h81);
    chk("ind_xfer_cnt", {48'h0, bus.xfer_cnt}, 64'd32);

    // Async reset mid-operation
    rst_n = 1'b0;
    step();
    rst_n        = 1'b1;
    bus.in_valid = 1'b1;
    bus.s        = 3'd1;
    bus.d        = 64'd101;
    step();
    bus.s = 3'd4;
    bus.d = 64'd104;
    step();
    bus.s = 3'd6;
    bus.d = 64'd106;
    step();
    bus.in_valid = 1'b0;
    chk("ar_pre_valid", {56'h0, bus.out_valid}, 64'h52);
    chk("ar_pre_cnt", {48'h0, bus.xfer_cnt}, 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", {56'h0, bus.out_valid}, 64'h0);
    chk("ar_xfer_cnt", {48'h0, bus.xfer_cnt}, 64'h0);
    chk("ar_y1", bus.y1, 64'h0);
    chk("ar_in_ready", {63'h0, bus.in_ready}, 64'h1);
    step();
    rst_n = 1'b1;

    // Counter wrap
    bus.out_ready = 8'hFF;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      bus.s = 3'(i);
      bus.d = 64'(i);
      step();
    end
    chk("wrap_ffff", {48'h0, bus.xfer_cnt}, 64'hFFFF);
    step();
    chk("wrap_zero", {48'h0, bus.xfer_cnt}, 64'h0);
    bus.in_valid = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
